note_sequencer: RTL and testbench

//  Step sequencer that drives the synth voice's note and gate inputs (tone_freq_bin, hold).

---
 rtl/note_sequencer.sv | 152 +++++++++++++++
 tb/tb_note_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Looping step sequencer driving a voice's note code and gate.
// Optional feature macro: SEQ_TRANSPOSE_EN adds a saturating per-step transpose input.
module note_sequencer #(
    parameter int FREQ_BITS      = 4,
    parameter int STEPS          = 8,
    parameter int QUARTER_CYCLES = 4410
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [3:0]               tempo,
    input  logic [1:0]               gate_len,
    input  logic [$clog2(STEPS)-1:0] last_step,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [FREQ_BITS:0]       wr_data,
`ifdef SEQ_TRANSPOSE_EN
    input  logic [1:0]               transpose,
`endif
    output logic [FREQ_BITS-1:0]     tone_freq_bin,
    output logic                     hold,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_strobe
);

    localparam int IDX_W = $clog2(STEPS);
    localparam int CNT_W = $clog2(16 * QUARTER_CYCLES + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

`ifdef SEQ_TRANSPOSE_EN
    function automatic logic [FREQ_BITS-1:0] sat_add(input logic [FREQ_BITS-1:0] note,
                                                     input logic [1:0] shift);
        logic [FREQ_BITS:0] sum;
        sum = {1'b0, note} + (FREQ_BITS+1)'(shift);
        return sum[FREQ_BITS] ? {FREQ_BITS{1'b1}} : sum[FREQ_BITS-1:0];
    endfunction
`endif

    state_t               state_r;
    logic [FREQ_BITS:0]   pattern_r [STEPS];
    logic [3:0]           tempo_r;
    logic [1:0]           gate_len_r;
    logic [CNT_W-1:0]     cyc_cnt_r;
    logic [1:0]           qtr_cnt_r;
    logic [FREQ_BITS-1:0] tone_r;
    logic                 hold_r;
    logic                 strobe_r;
    logic [IDX_W-1:0]     step_idx_r;

    logic [CNT_W-1:0]     q_last_s;
    logic                 cyc_wrap_s;
    logic                 step_end_s;
    logic [IDX_W-1:0]     last_eff_s;
    logic [IDX_W-1:0]     next_idx_s;
    logic                 start_s;
    logic [IDX_W-1:0]     start_idx_s;
    logic [FREQ_BITS:0]   entry_s;
    logic [FREQ_BITS-1:0] played_s;
    logic [CNT_W-1:0]     next_cyc_s;
    logic [1:0]           next_qtr_s;
    logic                 next_hold_s;

    // Step timing, loop wrap and step-start decode.
    always_comb begin
        q_last_s    = CNT_W'((32'(tempo_r) + 32'd1) * 32'(QUARTER_CYCLES) - 32'd1);
        cyc_wrap_s  = (cyc_cnt_r == q_last_s);
        step_end_s  = cyc_wrap_s && (qtr_cnt_r == 2'd3);
        last_eff_s  = (32'(last_step) > 32'(STEPS - 1)) ? IDX_W'(STEPS - 1) : last_step;
        next_idx_s  = (step_idx_r >= last_eff_s) ? {IDX_W{1'b0}} : step_idx_r + IDX_W'(1);
        next_cyc_s  = cyc_wrap_s ? {CNT_W{1'b0}} : cyc_cnt_r + CNT_W'(1);
        next_qtr_s  = cyc_wrap_s ? qtr_cnt_r + 2'd1 : qtr_cnt_r;
        // hold_r is already low on rest steps, so it only ever falls within a step
        next_hold_s = hold_r && ((gate_len_r == 2'd3) || (next_qtr_s <= gate_len_r));
        start_s     = 1'b0;
        start_idx_s = {IDX_W{1'b0}};
        case (state_r)
            IDLE: begin
                start_s     = run;
                start_idx_s = {IDX_W{1'b0}};
            end
            PLAY: begin
                start_s     = run && step_end_s;
                start_idx_s = next_idx_s;
            end
            default: begin
                start_s     = 1'b0;
                start_idx_s = {IDX_W{1'b0}};
            end
        endcase
        entry_s = pattern_r[start_idx_s];
`ifdef SEQ_TRANSPOSE_EN
        played_s = sat_add(entry_s[FREQ_BITS-1:0], transpose);
`else
        played_s = entry_s[FREQ_BITS-1:0];
`endif
    end

    // Pattern memory, play FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tempo_r    <= 4'd0;
            gate_len_r <= 2'd0;
            cyc_cnt_r  <= {CNT_W{1'b0}};
            qtr_cnt_r  <= 2'd0;
            tone_r     <= {FREQ_BITS{1'b0}};
            hold_r     <= 1'b0;
            strobe_r   <= 1'b0;
            step_idx_r <= {IDX_W{1'b0}};
            for (int i = 0; i < STEPS; i++) begin
                pattern_r[i] <= {1'b1, {FREQ_BITS{1'b0}}};
            end
        end else begin
            if (wr_en) begin
                pattern_r[wr_addr] <= wr_data;
            end
            if (start_s) begin
                state_r    <= PLAY;
                step_idx_r <= start_idx_s;
                strobe_r   <= 1'b1;
                tempo_r    <= tempo;
                gate_len_r <= gate_len;
                cyc_cnt_r  <= {CNT_W{1'b0}};
                qtr_cnt_r  <= 2'd0;
                hold_r     <= ~entry_s[FREQ_BITS];
                if (!entry_s[FREQ_BITS]) begin
                    tone_r <= played_s;
                end else begin
                    tone_r <= tone_r;
                end
            end else if ((state_r == PLAY) && run) begin
                strobe_r  <= 1'b0;
                cyc_cnt_r <= next_cyc_s;
                qtr_cnt_r <= next_qtr_s;
                hold_r    <= next_hold_s;
            end else begin
                // stopped: the pitch is kept so the envelope release stays in tune
                state_r    <= IDLE;
                strobe_r   <= 1'b0;
                hold_r     <= 1'b0;
                step_idx_r <= {IDX_W{1'b0}};
            end
        end
    end

    assign tone_freq_bin = tone_r;
    assign hold          = hold_r;
    assign step_idx      = step_idx_r;
    assign step_strobe   = strobe_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized and scenario-driven bench for note_sequencer against a per-step timeline model.
// Builds with or without SEQ_TRANSPOSE_EN, matching the RTL.
module tb_note_sequencer;
    localparam int FB = 4;
    localparam int ST = 8;
    localparam int QC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] tempo = 4'd0;
    logic [1:0] gate_len = 2'd0;
    logic [2:0] last_step = 3'd7;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [4:0] wr_data = 5'd0;
`ifdef SEQ_TRANSPOSE_EN
    logic [1:0] transpose = 2'd0;
`endif
    logic [3:0] tone_freq_bin;
    logic       hold;
    logic [2:0] step_idx;
    logic       step_strobe;

    int checks = 0;
    int errors = 0;

    // reference model state: position is a single elapsed-cycle count within the step
    int m_pat [ST];
    bit m_playing;
    int m_el, m_len, m_gate_cycles, m_gl;
    int m_idx, m_tone;
    bit m_hold, m_strobe, m_note;

    always #5 clk = ~clk;

    note_sequencer #(.FREQ_BITS(FB), .STEPS(ST), .QUARTER_CYCLES(QC)) dut (
        .clk(clk), .rst(rst), .run(run), .tempo(tempo), .gate_len(gate_len),
        .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SEQ_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .tone_freq_bin(tone_freq_bin), .hold(hold), .step_idx(step_idx),
        .step_strobe(step_strobe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_update();
        bit start;
        int nidx, tr, note;
        start = 1'b0;
        nidx  = 0;
        tr    = 0;
`ifdef SEQ_TRANSPOSE_EN
        tr = int'(transpose);
`endif
        if (rst) begin
            m_playing = 1'b0; m_tone = 0; m_hold = 1'b0; m_idx = 0; m_strobe = 1'b0;
            for (int i = 0; i < ST; i++) m_pat[i] = 16;
            return;
        end
        if (!m_playing) begin
            if (run) begin start = 1'b1; nidx = 0; end
        end else if (!run) begin
            m_playing = 1'b0; m_hold = 1'b0; m_idx = 0; m_strobe = 1'b0;
        end else begin
            m_el++;
            if (m_el == m_len) begin
                start = 1'b1;
                nidx = (m_idx >= int'(last_step)) ? 0 : m_idx + 1;
            end else begin
                m_strobe = 1'b0;
                m_hold = m_note && (m_gl == 3 || m_el < m_gate_cycles);
            end
        end
        if (start) begin
            m_playing = 1'b1;
            m_el = 0;
            m_idx = nidx;
            m_strobe = 1'b1;
            m_len = 4 * (int'(tempo) + 1) * QC;
            m_gl = int'(gate_len);
            m_gate_cycles = (m_gl + 1) * (int'(tempo) + 1) * QC;
            m_note = (m_pat[nidx] < 16);
            m_hold = m_note;
            if (m_note) begin
                note = m_pat[nidx] + tr;
                m_tone = (note > 15) ? 15 : note;
            end
        end
        if (wr_en) m_pat[wr_addr] = int'(wr_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("tone", 32'(tone_freq_bin), 32'(m_tone));
        check("hold", 32'(hold), 32'(m_hold));
        check("step_idx", 32'(step_idx), 32'(m_idx));
        check("strobe", 32'(step_strobe), 32'(m_strobe));
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; wr_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write(input int addr, input int data);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 5'(data);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic play(input int n);
        run = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // unwritten pattern: strobes only, gate and pitch stay low
        do_reset();
        tempo = 4'd0; gate_len = 2'd1; last_step = 3'd7;
        play(40);
        run = 1'b0; tick();

        // four-note loop with half-step gate
        do_reset();
        write(0, 3); write(1, 5); write(2, 7); write(3, 9);
        last_step = 3'd3;
        play(42);
        run = 1'b0; tick(); tick();

        // tied notes across the boundary, then a rest after a tie
        write(0, 2); write(1, 4); write(2, 16);
        gate_len = 2'd3; last_step = 3'd2;
        play(50);
        run = 1'b0; tick();

        // rest between notes, full-length loop wraps after step 7
        write(0, 6); write(1, 16); write(2, 8);
        gate_len = 2'd0; last_step = 3'd7;
        play(70);

        // stop mid-step, restart, then abort by reset and replay the cleared pattern
        run = 1'b0; tick(); tick();
        play(20);
        rst = 1'b1; tick(); rst = 1'b0;
        play(20);

`ifdef SEQ_TRANSPOSE_EN
        run = 1'b0; tick();
        write(0, 14); write(1, 4);
        last_step = 3'd1;
        transpose = 2'd3;
        play(6);
        transpose = 2'd2;
        play(10);
`endif

        // randomized phase
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            wr_en = ($urandom_range(0, 4) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 3) == 0) ? 5'(16 + $urandom_range(0, 15))
                                                  : 5'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) tempo = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) gate_len = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) last_step = 3'($urandom_range(0, 7));
`ifdef SEQ_TRANSPOSE_EN
            if ($urandom_range(0, 9) == 0) transpose = 2'($urandom_range(0, 3));
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
